uart_flash_loader: RTL
======================

// Module: uart_flash_loader
// PURPOSE
// Drives the datapath flash port (flash_en/flash_addr/flash_data) that preloads program memory.
// Receives a framed program image over a UART line and packs little-endian bytes into 32-bit words.
// Emits one flash write per word and holds the CPU in reset until the image is complete.
// Sits at top level between the board UART RX pin and the datapath/memory flash inputs.
// PARAMETERS
// WIDTH         32       data/address width; must be 32 (4 bytes per word)
// CLKS_PER_BIT  434      clk cycles per UART bit (50 MHz / 115200); must be >= 4
// BASE_ADDR     32'h0    byte address of first word written
// PORTS
// clk         in   1      system clock, all logic on rising edge
// rst         in   1      synchronous, active-high reset
// uart_rx     in   1      async serial input, idle high, 8N1, LSB first
// flash_en    out  1      one-cycle write strobe to memory flash port
// flash_addr  out  WIDTH  byte address of word being written
// flash_data  out  WIDTH  word being written
// cpu_hold    out  1      1 = keep CPU in reset (OR into core rst)
// done        out  1      1 = image fully written
// err         out  1      sticky framing error; cleared by next accepted sync byte
// BEHAVIOUR
// Reset values: flash_en=0, flash_addr=BASE_ADDR, flash_data=0, cpu_hold=1, done=0, err=0; both FSMs to idle.
// RX front end: 2-FF synchronizer on uart_rx, sync flops reset to 1; all RX logic uses synced value.
// RX FSM: R_IDLE -> R_START on synced 1->0 edge.
// R_START: wait CLKS_PER_BIT/2; if line high, glitch -> R_IDLE, no byte, no error.
// R_DATA: 8 samples every CLKS_PER_BIT, LSB first. R_STOP: sample after CLKS_PER_BIT.
// Stop=1 -> byte_valid pulse 1 cycle. Stop=0 -> frame_err pulse, byte dropped. Then R_IDLE.
// Loader FSM (consumes byte_valid / frame_err):
// - L_SYNC: wait for byte 8'hA5; other bytes ignored. On A5: err<=0, cpu_hold<=1, done<=0, word_idx<=0 -> L_LEN0.
// - L_LEN0: store N[7:0] -> L_LEN1. L_LEN1: store N[15:8].
//   N==0 -> L_DONE; else byte_idx<=0 -> L_DATA.
// - L_DATA: shift byte into word at lane byte_idx (lane 0 = bits 7:0). After byte_idx==3 -> L_WRITE.
// - L_WRITE (1 cycle): flash_en=1, flash_data=assembled word, flash_addr=BASE_ADDR+4*word_idx.
//   Then word_idx++. word_idx==N-1 -> L_DONE; else -> L_DATA.
// - L_DONE: cpu_hold=0, done=1. A5 -> restarts load as in L_SYNC. Other bytes ignored.
// Latency: flash_en asserts 2 clk after the byte_valid of the 4th byte (capture cycle, then L_WRITE).
// flash_addr/flash_data hold their last value while flash_en=0.
// Framing error in L_LEN0/L_LEN1/L_DATA/L_WRITE: err<=1, discard partial word, -> L_SYNC. cpu_hold stays 1.
// Words already written are not rolled back.
// Framing error in L_SYNC/L_DONE: err<=1, state unchanged.
// Wrap: N up to 65535; addresses compute mod 2^WIDTH, no saturation.
// rst mid-frame: aborts immediately to reset values. The next start edge is the first byte seen.
// Byte arriving while in L_WRITE cannot occur (byte period >> 1 cycle); no skid buffer required.
// TESTING (benches use CLKS_PER_BIT=8, BASE_ADDR=0)
// 1 Send A5 02 00 13 00 50 00 93 00 10 00 -> flash_en pulses x2: (0x0,0x00500013), (0x4,0x00100093); then done=1, cpu_hold=0.
// 2 Send 00 FF 12 A5 01 00 EF BE AD DE -> exactly one write (0x0,0xDEADBEEF); leading bytes ignored; err=0.
// 3 Send A5 00 00 -> no flash_en; done=1, cpu_hold=0 after 3rd byte.
// 4 A5 01 00 EF then BE with stop bit=0 -> no write, err=1, cpu_hold=1; then A5 01 00 78 56 34 12 -> err=0, write (0x0,0x12345678).
// 5 Assert rst for 1 cycle after 2 data bytes of a word -> all outputs at reset values;
//   then full frame A5 01 00 AA BB CC DD -> write (0x0,0xDDCCBBAA).
// 6 uart_rx low for 3 cycles then high -> no byte, no err; following valid A5 frame loads normally.

Source files
------------

// File: rtl/uart_flash_loader.sv
// UART (8N1) program-image receiver that packs little-endian bytes into words and
// writes them to the memory flash port, holding the CPU in reset until the image is complete.
module uart_flash_loader #(
    parameter int               WIDTH        = 32,
    parameter int               CLKS_PER_BIT = 434,
    parameter logic [WIDTH-1:0] BASE_ADDR    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx,
    output logic             flash_en,
    output logic [WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0] flash_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             err
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_SYNC, L_LEN0, L_LEN1, L_DATA, L_WRITE, L_DONE} ld_state_t;

    logic            rx_s1, rx_s2, rx_prev;
    rx_state_t       rstate;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_byte;
    logic            byte_valid, frame_err;

    ld_state_t       lstate;
    logic [15:0]     len, word_idx;
    logic [1:0]      byte_idx;
    logic [WIDTH-1:0] word;

    // Idle-high synchronizer; rx_prev gives the 1->0 start-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate     <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rstate)
                R_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_s2) rstate <= R_START;
                end
                R_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        rstate  <= rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                R_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        rx_byte <= {rx_s2, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rstate <= R_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                R_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        byte_valid <= rx_s2;
                        frame_err  <= !rx_s2;
                        rstate     <= R_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lstate     <= L_SYNC;
            len        <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            word       <= '0;
            flash_en   <= 1'b0;
            flash_addr <= BASE_ADDR;
            flash_data <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            flash_en <= 1'b0;
            case (lstate)
                L_SYNC, L_DONE: begin
                    if (byte_valid && rx_byte == 8'hA5) begin
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        word_idx <= '0;
                        lstate   <= L_LEN0;
                    end else if (frame_err) begin
                        err <= 1'b1;
                    end
                end
                L_LEN0: begin
                    if (frame_err) begin
                        err    <= 1'b1;
                        lstate <= L_SYNC;
                    end else if (byte_valid) begin
                        len[7:0] <= rx_byte;
                        lstate   <= L_LEN1;
                    end
                end
                L_LEN1: begin
                    if (frame_err) begin
                        err    <= 1'b1;
                        lstate <= L_SYNC;
                    end else if (byte_valid) begin
                        len[15:8] <= rx_byte;
                        if ({rx_byte, len[7:0]} == 16'd0) begin
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                            lstate   <= L_DONE;
                        end else begin
                            byte_idx <= '0;
                            lstate   <= L_DATA;
                        end
                    end
                end
                L_DATA: begin
                    if (frame_err) begin
                        err    <= 1'b1;
                        lstate <= L_SYNC;
                    end else if (byte_valid) begin
                        word[{byte_idx, 3'b000} +: 8] <= rx_byte;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) lstate <= L_WRITE;
                    end
                end
                L_WRITE: begin
                    if (frame_err) begin
                        err    <= 1'b1;
                        lstate <= L_SYNC;
                    end else begin
                        flash_en   <= 1'b1;
                        flash_data <= word;
                        flash_addr <= BASE_ADDR + (WIDTH'(word_idx) << 2);
                        word_idx   <= word_idx + 16'd1;
                        byte_idx   <= '0;
                        if (word_idx == len - 16'd1) begin
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                            lstate   <= L_DONE;
                        end else begin
                            lstate <= L_DATA;
                        end
                    end
                end
                default: lstate <= L_SYNC;
            endcase
        end
    end

endmodule
